// File: rtl/dequant_pipe.sv
// Two-stage per-lane dequantiser: y = ((x * scale) >>> QBITS) + offset, with scale/offset from a small table.
// Define DEQUANT_SAT_EN to clamp results to the signed DWIDTH range; otherwise results wrap.
module dequant_pipe #(
  parameter int DWIDTH = 16,
  parameter int QWIDTH = 8,
  parameter int LANES  = 4,
  parameter int NSETS  = 4,
  parameter int QBITS  = 8,
  localparam int SW    = (NSETS > 1) ? $clog2(NSETS) : 1
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      cfg_we,
  input  logic [SW-1:0]             cfg_sel,
  input  logic signed [DWIDTH-1:0]  cfg_scale,
  input  logic signed [DWIDTH-1:0]  cfg_offset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SW-1:0]             in_sel,
  input  logic                      in_last,
  input  logic [LANES*QWIDTH-1:0]   in_x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DWIDTH-1:0]   out_y,
  output logic                      out_last,
  output logic                      busy
);

  localparam int ZW  = QWIDTH + DWIDTH;
  localparam int SWD = DWIDTH + QWIDTH + 1;

  logic en;

  logic signed [DWIDTH-1:0] tbl_scale  [NSETS];
  logic signed [DWIDTH-1:0] tbl_offset [NSETS];
  logic signed [DWIDTH-1:0] lk_scale;
  logic signed [DWIDTH-1:0] lk_offset;

  logic                     s1_valid;
  logic                     s1_last;
  logic signed [DWIDTH-1:0] s1_offset;
  logic signed [ZW-1:0]     s1_z [LANES];
  logic signed [ZW-1:0]     z_next [LANES];

  logic                     s2_valid;
  logic                     s2_last;
  logic signed [DWIDTH-1:0] s2_y [LANES];
  logic signed [DWIDTH-1:0] y_next [LANES];

  assign en       = !s2_valid || out_ready;
  assign in_ready = en;

  // Table writes land on the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      for (int i = 0; i < NSETS; i++) begin
        tbl_scale[i]  <= '0;
        tbl_offset[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_sel) < NSETS)) begin
      tbl_scale[cfg_sel]  <= cfg_scale;
      tbl_offset[cfg_sel] <= cfg_offset;
    end
  end

  always_comb begin
    lk_scale  = '0;
    lk_offset = '0;
    if (32'(in_sel) < NSETS) begin
      lk_scale  = tbl_scale[in_sel];
      lk_offset = tbl_offset[in_sel];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      z_next[i] = ZW'($signed(in_x[i*QWIDTH +: QWIDTH])) * ZW'(lk_scale);
    end
  end

`ifdef DEQUANT_SAT_EN
  localparam logic signed [SWD-1:0] Y_MAX = {{(QWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [SWD-1:0] Y_MIN = {{(QWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic signed [SWD-1:0] s_full [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s_full[i] = SWD'(s1_z[i] >>> QBITS) + SWD'(s1_offset);
      if (s_full[i] > Y_MAX) begin
        y_next[i] = {1'b0, {(DWIDTH-1){1'b1}}};
      end else if (s_full[i] < Y_MIN) begin
        y_next[i] = {1'b1, {(DWIDTH-1){1'b0}}};
      end else begin
        y_next[i] = DWIDTH'(s_full[i]);
      end
    end
  end
`else
  // Only the low DWIDTH bits survive wrapping, so the sum is formed at that width directly.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      y_next[i] = DWIDTH'(s1_z[i] >>> QBITS) + s1_offset;
    end
  end
`endif

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_offset <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_z[i] <= '0;
        s2_y[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last   <= in_last;
        s1_offset <= lk_offset;
        for (int i = 0; i < LANES; i++) begin
          s1_z[i] <= z_next[i];
        end
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        for (int i = 0; i < LANES; i++) begin
          s2_y[i] <= y_next[i];
        end
      end
    end
  end

  always_comb begin
    out_y = '0;
    for (int i = 0; i < LANES; i++) begin
      out_y[i*DWIDTH +: DWIDTH] = s2_y[i];
    end
  end

  assign out_valid = s2_valid;
  assign out_last  = s2_last;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_dequant_pipe.sv
// Scoreboard bench for dequant_pipe: a driver pushes model results, a monitor pops on each output transfer.
module tb_dequant_pipe;
  localparam int DW = 16;
  localparam int QW = 8;
  localparam int LN = 4;
  localparam int NS = 4;
  localparam int QB = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic xrst = 1'b1;
  logic cfg_we = 1'b0;
  logic [SW-1:0] cfg_sel = '0;
  logic signed [DW-1:0] cfg_scale = '0;
  logic signed [DW-1:0] cfg_offset = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [SW-1:0] in_sel = '0;
  logic in_last = 1'b0;
  logic [LN*QW-1:0] in_x = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [LN*DW-1:0] out_y;
  logic out_last;
  logic busy;

  dequant_pipe dut (
    .clk(clk), .xrst(xrst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_scale(cfg_scale), .cfg_offset(cfg_offset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_last(in_last), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LN*DW-1:0] y;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int m_scale [NS];
  int m_offset [NS];
  logic held_pending = 1'b0;
  logic [LN*DW-1:0] held_y;
  logic held_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: floor((x*scale)/2^QB) + offset, then clamp or keep the low DW bits.
  function automatic logic [LN*DW-1:0] ref_y(input int sel, input logic [LN*QW-1:0] x);
    logic [LN*DW-1:0] r;
    longint xi, sc, off, z, q, s, d;
    r = '0;
    d = longint'(1) << QB;
    for (int i = 0; i < LN; i++) begin
      xi  = longint'($signed(x[i*QW +: QW]));
      sc  = (sel < NS) ? longint'(m_scale[sel]) : 0;
      off = (sel < NS) ? longint'(m_offset[sel]) : 0;
      z = xi * sc;
      q = z / d;
      if ((z % d != 0) && (z < 0)) q = q - 1;
      s = q + off;
`ifdef DEQUANT_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      r[i*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  task automatic step(input logic v, input int sel, input logic [LN*QW-1:0] x, input logic last,
                      input logic ordy, input logic we, input int csel, input int cscale, input int coff);
    exp_t e;
    @(negedge clk);
    in_valid   = v;
    in_sel     = sel[SW-1:0];
    in_x       = x;
    in_last    = last;
    out_ready  = ordy;
    cfg_we     = we;
    cfg_sel    = csel[SW-1:0];
    cfg_scale  = cscale[DW-1:0];
    cfg_offset = coff[DW-1:0];
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
    if (v && in_ready) begin
      e.y = ref_y(sel, x);
      e.last = last;
      sb.push_back(e);
    end
    if (we && csel < NS) begin
      m_scale[csel]  = int'($signed(cfg_scale));
      m_offset[csel] = int'($signed(cfg_offset));
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 0, '0, 1'b0, ordy, 1'b0, 0, 0, 0);
  endtask

  task automatic cfg(input int csel, input int cscale, input int coff);
    step(1'b0, 0, '0, 1'b0, 1'b1, 1'b1, csel, cscale, coff);
  endtask

  // Monitor: samples between negedge drive and the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (xrst) begin
        held_pending = 1'b0;
      end else if (out_valid) begin
        if (held_pending) begin
          check("hold_y", {out_y}, {held_y});
          check("hold_last", {63'd0, out_last}, {63'd0, held_last});
        end
        if (out_ready) begin
          held_pending = 1'b0;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got y=%h with empty scoreboard", out_y);
          end else begin
            e = sb.pop_front();
            check("out_y", out_y, e.y);
            check("out_last", {63'd0, out_last}, {63'd0, e.last});
          end
        end else begin
          held_pending = 1'b1;
          held_y = out_y;
          held_last = out_last;
        end
      end else if (held_pending) begin
        total++; bad++;
        $display("FAIL hold_valid: out_valid got 0 expected 1 while stalled");
        held_pending = 1'b0;
      end
    end
  end

  initial begin
    logic [LN*QW-1:0] x;
    logic [3:0] pat;
    for (int i = 0; i < NS; i++) begin
      m_scale[i] = 0;
      m_offset[i] = 0;
    end
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_y", {out_y}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    repeat (2) @(negedge clk);
    xrst = 1'b0;

    cfg(0, 16'h0180, 10);
    cfg(1, 16'h7FFF, 16'h7FFF);
    cfg(2, 16'h7FFF, -32768);

    // Latency: beat accepted into an empty pipe appears two edges later.
    x = '0; x[7:0] = 8'hFD;
    step(1'b1, 0, x, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(1'b1);
    check("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    check("lat_cycle1_busy", {63'd0, busy}, 64'd1);
    idle(1'b1);
    check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    check("lat_y_lane0", {48'd0, out_y[15:0]}, 64'd5);

    x = '0; x[7:0] = 8'd127;
    step(1'b1, 1, x, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    x = '0; x[7:0] = 8'h80;
    step(1'b1, 2, x, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    repeat (3) idle(1'b1);

    // Same-cycle write and lookup of set 0: the beat must see the old scale.
    x = '0; x[7:0] = 8'd4;
    step(1'b1, 0, x, 1'b0, 1'b1, 1'b1, 0, 16'h0200, 10);
    step(1'b1, 0, x, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    repeat (3) idle(1'b1);

    // Eight-beat frame under a 1,0,0,1 ready pattern.
    pat = 4'b1001;
    for (int b = 0; b < 8; b++) begin
      logic sent;
      sent = 1'b0;
      for (int c = 0; c < 40 && !sent; c++) begin
        int n0;
        n0 = sb.size();
        step(1'b1, b % 3, $urandom, (b == 7), pat[3 - ((total + c) % 4)], 1'b0, 0, 0, 0);
        sent = (sb.size() > n0);
      end
      if (!sent) begin
        total++; bad++;
        $display("FAIL stream_accept: beat %0d not accepted within budget", b);
      end
    end
    repeat (6) idle(1'b1);
    check("stream_drained", {32'd0, 32'(sb.size())}, 64'd0);

    // Randomized traffic with occasional table updates.
    for (int c = 0; c < 300; c++) begin
      logic we;
      we = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, NS-1), $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, we, $urandom_range(0, NS-1), $urandom_range(0, 65535),
           $urandom_range(0, 65535));
    end
    repeat (6) idle(1'b1);
    check("random_drained", {32'd0, 32'(sb.size())}, 64'd0);

    // Reset with two beats in flight.
    step(1'b1, 1, $urandom, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 2, $urandom, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    xrst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_out_y", {out_y}, 64'd0);
    sb.delete();
    for (int i = 0; i < NS; i++) begin
      m_scale[i] = 0;
      m_offset[i] = 0;
    end
    repeat (2) @(negedge clk);
    xrst = 1'b0;
    step(1'b1, 1, 32'h7F7F7F7F, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 0, 32'h80808080, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    repeat (5) idle(1'b1);
    check("post_rst_drained", {32'd0, 32'(sb.size())}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
